// File: rtl/sram_like_axi_bridge.sv
// sram_like_axi_bridge
//
// Bridges two SRAM-like masters (instruction side and data side) onto a single
// AXI master port, one transaction at a time. The data side wins arbitration in
// IDLE. Reads go IDLE -> RD_ADDR -> RD_DATA -> IDLE; data writes go
// IDLE -> WR_REQ -> WR_RESP -> IDLE, with AW and W issued together and retired
// independently.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   inst_*                instruction-side SRAM-like port (read only)
//   data_*                data-side SRAM-like port (read / write)
//   ar*, r*               AXI read address / read data channels
//   aw*, w*, b*           AXI write address / write data / write response channels
module sram_like_axi_bridge (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdAddr = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StWrResp = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_q, src_d;       // 0 = inst, 1 = data
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic grant_data, grant_inst;
    logic aw_hs, w_hs;
    logic rd_fire, wr_fire;

    // Only the response ready ever qualifies a response, so stray
    // rvalid/bvalid outside their state have no effect.
    assign rd_fire = (state_q == StRdData) && rvalid && !rst;
    assign wr_fire = (state_q == StWrResp) && bvalid && !rst;

    // Grant only from IDLE, so no grant can coincide with a data_ok.
    assign grant_data = (state_q == StIdle) && data_req && !rst;
    assign grant_inst = (state_q == StIdle) && inst_req && !data_req && !rst;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        src_d     = src_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            StIdle: begin
                if (grant_data) begin
                    addr_d  = data_addr;
                    size_d  = data_size;
                    wdata_d = data_wdata;
                    src_d   = 1'b1;
                    state_d = data_wr ? StWrReq : StRdAddr;
                end else if (grant_inst) begin
                    addr_d  = inst_addr;
                    size_d  = inst_size;
                    wdata_d = 32'h0;
                    src_d   = 1'b0;
                    state_d = StRdAddr;
                end
            end
            StRdAddr: begin
                if (arready) state_d = StRdData;
            end
            StRdData: begin
                if (rvalid) state_d = StIdle;
            end
            StWrReq: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                // Covers both handshakes landing in the same cycle.
                if (aw_done_d && w_done_d) begin
                    state_d   = StWrResp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWrResp: begin
                if (bvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= 32'h0;
            size_q    <= 2'd0;
            wdata_q   <= 32'h0;
            src_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            src_q     <= src_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // SRAM-like side
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = rd_fire && !src_q;
    assign data_data_ok = (rd_fire && src_q) || wr_fire;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // Valid/ready purely from state decode and done flags.
    assign arvalid = (state_q == StRdAddr) && !rst;
    assign rready  = (state_q == StRdData) && !rst;
    assign awvalid = (state_q == StWrReq) && !aw_done_q && !rst;
    assign wvalid  = (state_q == StWrReq) && !w_done_q && !rst;
    assign bready  = (state_q == StWrResp) && !rst;

    assign arid    = {3'b000, src_q};
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = 4'd1;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid   = 4'd1;
    assign wdata = wdata_q;
    assign wlast = 1'b1;

    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    logic unused_inputs;
    assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bresp};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Self-checking bench for sram_like_axi_bridge: directed scenarios plus a random
// back-to-back run against a delay-programmable AXI slave, checked every cycle
// against a transaction-level model and an addr_ok/data_ok order scoreboard.
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid, wid, arcache, awcache;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, rready, awvalid, wvalid, bready, wlast;
    logic [3:0]  wstrb;
    logic        arready = 0, rvalid = 0, rlast = 1, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;

    sram_like_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- AXI slave with programmable delays ----------------
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] r_data_val = 0;
    logic force_rvalid = 0;

    always @(posedge clk) begin
        #1;
        if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (rready) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
        else begin rvalid = 0; r_cnt = 0; end
        rvalid = rvalid | force_rvalid;
        rdata = r_data_val;
        if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (bready) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
        else begin bvalid = 0; b_cnt = 0; end
    end

    // ---------------- transaction-level model ----------------
    localparam int PIdle = 0, PAr = 1, PR = 2, PW = 3, PB = 4;
    int          m_phase = PIdle;
    bit          m_src = 0, m_wr = 0, m_aw_pend = 0, m_w_pend = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [1:0]  m_size = 0;

    // Byte lanes covered by an access of 2**sz bytes, aligned down to its size.
    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        int nb, off, m;
        nb  = (sz >= 2) ? 4 : (1 << sz);
        off = int'(a[1:0]) & ~(nb - 1);
        m   = ((1 << nb) - 1) << off;
        return m[3:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = PIdle; m_aw_pend = 0; m_w_pend = 0;
        end else begin
            case (m_phase)
                PIdle: begin
                    if (data_req) begin
                        m_src = 1; m_wr = data_wr; m_addr = data_addr;
                        m_size = data_size; m_wdata = data_wdata;
                        m_phase = data_wr ? PW : PAr;
                        m_aw_pend = 1; m_w_pend = 1;
                    end else if (inst_req) begin
                        m_src = 0; m_wr = 0; m_addr = inst_addr;
                        m_size = inst_size; m_wdata = 0;
                        m_phase = PAr;
                    end
                end
                PAr: if (arready) m_phase = PR;
                PR:  if (rvalid) m_phase = PIdle;
                PW: begin
                    if (m_aw_pend && awready) m_aw_pend = 0;
                    if (m_w_pend && wready) m_w_pend = 0;
                    if (!m_aw_pend && !m_w_pend) m_phase = PB;
                end
                PB:  if (bvalid) m_phase = PIdle;
                default: m_phase = PIdle;
            endcase
        end
    end

    // ---------------- per-cycle compare + order scoreboard ----------------
    bit sb[$];

    always @(negedge clk) begin
        bit e_iaok, e_daok, e_idok, e_ddok;
        if (rst) begin
            chk("rst_arvalid", 32'(arvalid), 0);
            chk("rst_rready", 32'(rready), 0);
            chk("rst_awvalid", 32'(awvalid), 0);
            chk("rst_wvalid", 32'(wvalid), 0);
            chk("rst_bready", 32'(bready), 0);
            chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
            sb.delete();
        end else begin
            e_daok = (m_phase == PIdle) && data_req;
            e_iaok = (m_phase == PIdle) && inst_req && !data_req;
            e_idok = (m_phase == PR) && rvalid && !m_src;
            e_ddok = ((m_phase == PR) && rvalid && m_src) || ((m_phase == PB) && bvalid);
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
            chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
            chk("arvalid", 32'(arvalid), 32'(m_phase == PAr));
            chk("rready", 32'(rready), 32'(m_phase == PR));
            chk("awvalid", 32'(awvalid), 32'(m_phase == PW && m_aw_pend));
            chk("wvalid", 32'(wvalid), 32'(m_phase == PW && m_w_pend));
            chk("bready", 32'(bready), 32'(m_phase == PB));
            if (m_phase == PAr) begin
                chk("araddr", araddr, m_addr);
                chk("arsize", 32'(arsize), 32'(m_size));
                chk("arid", 32'(arid), 32'(m_src));
            end
            if (m_phase == PW && m_aw_pend) begin
                chk("awaddr", awaddr, m_addr);
                chk("awsize", 32'(awsize), 32'(m_size));
            end
            if (m_phase == PW && m_w_pend) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", 32'(wstrb), 32'(model_strb(m_size, m_addr)));
            end
            if (e_idok) chk("inst_rdata", inst_rdata, rdata);
            if (e_ddok && !m_wr) chk("data_rdata", data_rdata, rdata);

            if (inst_addr_ok) sb.push_back(1'b0);
            if (data_addr_ok) sb.push_back(1'b1);
            if (inst_data_ok || data_data_ok) begin
                if (sb.size() == 0) chk("sb_unmatched_data_ok", 1, 0);
                else chk("sb_order", 32'(data_data_ok), 32'(sb.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit sel_sig(input int sel);
        case (sel)
            0: return inst_addr_ok;
            1: return data_addr_ok;
            2: return inst_data_ok;
            3: return data_data_ok;
            4: return rready;
            default: return awvalid;
        endcase
    endfunction

    // Returns at the negedge where the selected signal is high.
    task automatic wait_for(input int sel, input string nm);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sel_sig(sel)) break;
        end
        if (k == 100) chk({"timeout_", nm}, 0, 1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the grant with req dropped.
    task automatic issue(input bit is_data, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (is_data) begin
            data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        end else begin
            inst_req = 1; inst_size = sz; inst_addr = a;
        end
        wait_for(is_data ? 1 : 0, "addr_ok");
        @(posedge clk); #1;
        if (is_data) data_req = 0; else inst_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, rises;
        bit prev_b;
        repeat (3) @(negedge clk);
        chk("tie_arlen", 32'(arlen), 0);
        chk("tie_awburst", 32'(awburst), 1);
        chk("tie_awid_wid", 32'({awid, wid}), 32'h11);
        chk("tie_wlast", 32'(wlast), 1);
        chk("tie_cache_prot", 32'({arcache, awcache, arprot, awprot, arlock, awlock}), 0);
        @(posedge clk); #1; rst = 0;

        // Inst read
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00000; r_data_val = 32'h3C080000;
        @(negedge clk); chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        @(posedge clk); #1; inst_req = 0;
        @(negedge clk);
        chk("t1_arvalid", 32'(arvalid), 1);
        chk("t1_arid", 32'(arid), 0);
        chk("t1_arsize", 32'(arsize), 2);
        chk("t1_araddr", araddr, 32'hBFC00000);
        wait_for(2, "t1_data_ok");
        chk("t1_inst_rdata", inst_rdata, 32'h3C080000);
        @(posedge clk); #1;

        // Simultaneous requests: data first, inst after data_data_ok
        ar_dly = 1; r_dly = 2;
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00010;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000004;
        @(negedge clk);
        chk("t2_data_addr_ok", 32'(data_addr_ok), 1);
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
        @(posedge clk); #1; data_req = 0;
        @(negedge clk); chk("t2_arid", 32'(arid), 1);
        wait_for(3, "t2_data_ok");
        chk("t2_inst_blocked", 32'(inst_addr_ok), 0);
        @(negedge clk); chk("t2_inst_grant_next", 32'(inst_addr_ok), 1);
        @(posedge clk); #1; inst_req = 0;
        wait_for(2, "t2_inst_data_ok");
        @(posedge clk); #1;

        // Byte write, awready two cycles before wready
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 2; b_dly = 1;
        issue(1, 1, 2'd0, 32'h80000003, 32'h000000AB);
        wait_for(5, "t3_awvalid");
        chk("t3_wstrb", 32'(wstrb), 32'h8);
        chk("t3_awaddr", awaddr, 32'h80000003);
        chk("t3_wdata", wdata, 32'h000000AB);
        pulses = 0; rises = 0; prev_b = 0;
        repeat (15) begin
            @(negedge clk);
            if (data_data_ok) pulses++;
            if (bready && !prev_b) rises++;
            prev_b = bready;
        end
        chk("t3_data_ok_pulses", 32'(pulses), 1);
        chk("t3_bready_phases", 32'(rises), 1);
        @(posedge clk); #1;

        // Half write, both handshakes in the same cycle
        w_dly = 0; b_dly = 0;
        issue(1, 1, 2'd1, 32'h80000002, 32'h12345678);
        @(negedge clk);
        chk("t4_wstrb", 32'(wstrb), 32'hC);
        chk("t4_both_valid", 32'({awvalid, wvalid}), 32'h3);
        @(negedge clk);
        chk("t4_bready", 32'(bready), 1);
        chk("t4_valids_low", 32'({awvalid, wvalid}), 0);
        repeat (2) @(posedge clk); #1;

        // Reset during RD_DATA, then a late rvalid
        r_dly = 20;
        issue(0, 0, 2'd2, 32'hBFC00100, 0);
        wait_for(4, "t5_rready");
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        chk("t5_rst_rready", 32'(rready), 0);
        @(posedge clk); #1; rst = 0; force_rvalid = 1; r_dly = 0;
        @(negedge clk);
        chk("t5_late_rvalid_ignored", 32'(inst_data_ok), 0);
        chk("t5_idle_arvalid", 32'(arvalid), 0);
        @(posedge clk); #1; force_rvalid = 0;

        // Random back-to-back
        for (int i = 0; i < 40; i++) begin
            bit d, w;
            d = 1'($urandom_range(0, 1));
            w = d && 1'($urandom_range(0, 1));
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3);
            r_data_val = $urandom;
            issue(d, w, 2'($urandom_range(0, 2)), 32'h80000000 | ($urandom & 32'hFFF),
                  $urandom);
        end
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (m_phase == PIdle && sb.size() == 0) break;
            end
            chk("drain_sb_empty", 32'(sb.size()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_axi_bridge.md
SRAM_LIKE_AXI_BRIDGE -- requirements
Module: sram_like_axi_bridge

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rst input 1, sampled on posedge clk.
REQ-002 inst_req, inst_wr  input  1,1  instruction-side request and write flag; inst_wr is ignored and treated as 0.
REQ-003 inst_size, inst_addr, inst_wdata  input  2,32,32  instruction access size, byte address and write data; inst_wdata is unused.
REQ-004 inst_addr_ok, inst_data_ok  output  1,1  instruction address accepted; instruction read data valid.
REQ-005 inst_rdata  output  32  instruction read data, valid only while inst_data_ok=1.
REQ-006 data_req, data_wr  input  1,1  data-side request; write when data_wr=1.
REQ-007 data_size, data_addr, data_wdata  input  2,32,32  data access size (0=byte, 1=half, 2=word), byte address and write data.
REQ-008 data_addr_ok, data_data_ok  output  1,1  data address accepted; data read data valid or write complete.
REQ-009 data_rdata  output  32  data read data, valid only while data_data_ok=1.
REQ-010 arid, araddr, arsize, arvalid  output  4,32,3,1  AXI read address channel; arready is an input of width 1.
REQ-011 rid, rdata, rlast, rvalid  input  4,32,1,1  AXI read data channel; rready is an output of width 1.
REQ-012 awaddr, awsize, awvalid  output  32,3,1  AXI write address channel; awready is an input of width 1.
REQ-013 wdata, wstrb, wlast, wvalid  output  32,4,1,1  AXI write data channel; wready is an input of width 1.
REQ-014 bvalid  input  1  AXI write response valid; bready is an output of width 1.
REQ-015 Tie-offs SHALL be constant: arlen/awlen=0, arburst/awburst=2'b01, arlock/awlock=0, arcache/awcache=0, arprot/awprot=0, awid=1, wid=1, wlast=1; bresp and rresp are ignored.

Function
REQ-016 The bridge SHALL hold at most one outstanding transaction, using FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
REQ-017 In IDLE, data_req SHALL have priority over inst_req; the granted side sees addr_ok=1 combinationally in that cycle and the other side sees addr_ok=0.
REQ-018 On grant, the bridge SHALL register addr, size, wdata and the requester (0=inst, 1=data); the next state is WR_REQ for a data write and RD_ADDR otherwise.
REQ-019 addr_ok SHALL be 0 in every state except IDLE, and addr_ok SHALL never be 1 when req=0.
REQ-020 In RD_ADDR, arvalid SHALL be 1 with araddr=the registered addr, arsize={1'b0,size} and arid=the requester; the state moves to RD_DATA on arready.
REQ-021 In RD_DATA, rready SHALL be 1; on rvalid the requester's data_ok SHALL be 1 for exactly that cycle, its rdata=rdata, and the state returns to IDLE.
REQ-022 In WR_REQ, awvalid and wvalid SHALL be raised together, each deasserting individually after its own handshake (aw_done and w_done flags); the state moves to WR_RESP once both handshakes have completed, including the case where both complete in the same cycle.
REQ-023 wstrb SHALL be decoded as follows: size 0 gives 4'b0001<<addr[1:0]; size 1 gives addr[1] ? 4'b1100 : 4'b0011; size 2 gives 4'b1111. awaddr SHALL be the registered addr unmodified.
REQ-024 In WR_RESP, bready SHALL be 1; on bvalid, data_data_ok SHALL pulse for one cycle and the state returns to IDLE.
REQ-025 A new grant SHALL NOT occur in the same cycle that data_ok is asserted; the earliest next addr_ok is the following cycle.
REQ-026 A response arriving while not in the matching state (for example rvalid in IDLE) SHALL be ignored, because the corresponding ready is 0.
REQ-027 All AXI valid and ready outputs SHALL come directly from registers or state decode, with no combinational path from any AXI input to any AXI valid output.

Reset
REQ-028 While rst=1, the state SHALL be IDLE; arvalid, rready, awvalid, wvalid, bready, aw_done, w_done and both data_ok outputs SHALL be 0; the registered addr and wdata SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction without completing it; no data_ok is produced for it.

Verification
REQ-030 Inst read: inst_req=1, addr 0xBFC00000, size 2 -> inst_addr_ok in cycle 0, arvalid in cycle 1 with arid=0 and arsize=2, then rvalid with rdata 0x3C080000 -> inst_data_ok=1 and inst_rdata=0x3C080000 for one cycle.
REQ-031 Simultaneous inst_req and data_req (data read at 0x80000004) -> data is granted first with arid=1; inst_addr_ok stays 0 until data_data_ok, then inst is granted on the next cycle.
REQ-032 Byte write: data_wr=1, size 0, addr 0x80000003, wdata 0x000000AB -> wstrb=4'b1000; awready arrives 2 cycles before wready -> a single bready phase, then one data_data_ok pulse.
REQ-033 Half write at addr 0x80000002 with awready and wready in the same cycle -> wstrb=4'b1100, WR_RESP entered on the next cycle.
REQ-034 rst=1 asserted while in RD_DATA -> the next cycle shows IDLE with all valid and ready outputs 0; a late rvalid produces no inst_data_ok.
REQ-035 Random back-to-back requests against an AXI slave model with random ready delays -> every addr_ok is matched by exactly one data_ok, in order.
